// File: rtl/uart_cmd_parser_if.sv
// ============================================================================
// uart_cmd_parser_if : RX byte stream in, TX reply handshake and LED state out
// Rev 1.0
// ============================================================================
`default_nettype none

interface uart_cmd_parser_if;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_perr;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic [3:0] led_cmd;
    logic       frame_err;
    logic [7:0] drop_cnt;

    modport master (
        output rx_valid, rx_byte, rx_perr, tx_busy,
        input  tx_start, tx_byte, led_cmd, frame_err, drop_cnt
    );

    modport slave (
        input  rx_valid, rx_byte, rx_perr, tx_busy,
        output tx_start, tx_byte, led_cmd, frame_err, drop_cnt
    );
endinterface

`default_nettype wire

// File: rtl/uart_cmd_parser.sv
// ============================================================================
// uart_cmd_parser : parses 'L'<hex>CR / 'R'CR frames, drives LED register,
//                   and issues a one-byte ASCII reply per frame.  Rev 1.0
// ============================================================================
`default_nettype none

module uart_cmd_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 16_000_000,
    parameter int unsigned CNT_W          = 24
) (
    input  wire logic        clk,
    input  wire logic        rst,
    uart_cmd_parser_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GOT_L     = 3'd1,
        S_GOT_DIG   = 3'd2,
        S_GOT_R     = 3'd3,
        S_RESP      = 3'd4,
        S_RESP_WAIT = 3'd5
    } state_t;

    localparam logic [7:0]       C_CHR_L = 8'h4C;
    localparam logic [7:0]       C_CHR_R = 8'h52;
    localparam logic [7:0]       C_CHR_K = 8'h4B;
    localparam logic [7:0]       C_CHR_E = 8'h45;
    localparam logic [7:0]       C_CR    = 8'h0D;
    localparam logic [7:0]       C_LF    = 8'h0A;
    localparam logic [CNT_W-1:0] C_TMAX  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_nibble;
    logic [3:0]         r_led;
    logic [7:0]         r_tx_byte;
    logic               r_frame_err;
    logic [7:0]         r_drop_cnt;
    logic [CNT_W-1:0]   r_timer;
    logic               r_wait_first;

    logic               w_is_digit;
    logic               w_is_alpha;
    logic               w_is_hex;
    logic [3:0]         w_hex_val;
    logic [7:0]         w_led_ascii;
    logic               w_timeout;
    logic               w_in_got;
    logic               w_next_in_got;
    logic               w_err;
    logic               w_ok;
    logic [7:0]         w_ok_byte;
    logic               w_reply_load;
    logic [7:0]         w_reply_byte;
    logic               w_nib_load;
    logic               w_led_load;
    logic               w_tx_start;
    logic               w_drop;

    // Letters 'A'-'F' and 'a'-'f' share the low nibble 1..6, so +9 gives 10..15.
    assign w_is_digit  = (bus.rx_byte >= 8'h30) && (bus.rx_byte <= 8'h39);
    assign w_is_alpha  = ((bus.rx_byte >= 8'h41) && (bus.rx_byte <= 8'h46)) ||
                         ((bus.rx_byte >= 8'h61) && (bus.rx_byte <= 8'h66));
    assign w_is_hex    = w_is_digit || w_is_alpha;
    assign w_hex_val   = w_is_digit ? bus.rx_byte[3:0] : (bus.rx_byte[3:0] + 4'd9);
    assign w_led_ascii = (r_led < 4'd10) ? {4'h3, r_led} : (8'h37 + {4'h0, r_led});
    assign w_timeout   = (r_timer == C_TMAX);
    assign w_in_got    = (r_state == S_GOT_L) || (r_state == S_GOT_DIG) || (r_state == S_GOT_R);
    assign w_next_in_got = (w_next_state == S_GOT_L) || (w_next_state == S_GOT_DIG) ||
                           (w_next_state == S_GOT_R);

    always_comb begin
        w_next_state = r_state;
        w_err        = 1'b0;
        w_ok         = 1'b0;
        w_ok_byte    = C_CHR_K;
        w_nib_load   = 1'b0;
        w_led_load   = 1'b0;
        w_tx_start   = 1'b0;
        w_drop       = 1'b0;
        w_reply_load = 1'b0;
        w_reply_byte = r_tx_byte;

        unique case (r_state)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_perr)                 w_err = 1'b1;
                    else if (bus.rx_byte == C_CHR_L) w_next_state = S_GOT_L;
                    else if (bus.rx_byte == C_CHR_R) w_next_state = S_GOT_R;
                    else if ((bus.rx_byte != C_CR) && (bus.rx_byte != C_LF)) w_err = 1'b1;
                end
            end
            S_GOT_L: begin
                if (bus.rx_valid) begin
                    if (!bus.rx_perr && w_is_hex) begin
                        w_nib_load   = 1'b1;
                        w_next_state = S_GOT_DIG;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_err = 1'b1;
                end
            end
            S_GOT_DIG: begin
                if (bus.rx_valid) begin
                    if (!bus.rx_perr && (bus.rx_byte == C_CR)) begin
                        w_led_load = 1'b1;
                        w_ok       = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_err = 1'b1;
                end
            end
            S_GOT_R: begin
                if (bus.rx_valid) begin
                    if (!bus.rx_perr && (bus.rx_byte == C_CR)) begin
                        w_ok      = 1'b1;
                        w_ok_byte = w_led_ascii;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_err = 1'b1;
                end
            end
            S_RESP: begin
                w_drop = bus.rx_valid;
                if (!bus.tx_busy) begin
                    w_tx_start   = 1'b1;
                    w_next_state = S_RESP_WAIT;
                end
            end
            S_RESP_WAIT: begin
                w_drop = bus.rx_valid;
                // TX raises busy only a cycle after tx_start, so its first cycle here is blind.
                if (!r_wait_first && !bus.tx_busy) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase

        if (w_err) begin
            w_reply_load = 1'b1;
            w_reply_byte = C_CHR_E;
            w_next_state = S_RESP;
        end else if (w_ok) begin
            w_reply_load = 1'b1;
            w_reply_byte = w_ok_byte;
            w_next_state = S_RESP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_nibble     <= 4'h0;
            r_led        <= 4'h0;
            r_tx_byte    <= 8'h00;
            r_frame_err  <= 1'b0;
            r_drop_cnt   <= 8'h00;
            r_timer      <= '0;
            r_wait_first <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_frame_err  <= w_err;
            r_wait_first <= (r_state == S_RESP) && (w_next_state == S_RESP_WAIT);
            if (w_reply_load) r_tx_byte <= w_reply_byte;
            if (w_nib_load)   r_nibble  <= w_hex_val;
            if (w_led_load)   r_led     <= r_nibble;
            if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
            if (w_in_got && w_next_in_got && !bus.rx_valid) r_timer <= r_timer + 1'b1;
            else                                            r_timer <= '0;
        end
    end

    assign bus.tx_start  = w_tx_start;
    assign bus.tx_byte   = r_tx_byte;
    assign bus.led_cmd   = r_led;
    assign bus.frame_err = r_frame_err;
    assign bus.drop_cnt  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
// ============================================================================
// tb_uart_cmd_parser : directed checks of framing, replies, timeout, drops,
//                      TX back-pressure and mid-reply reset.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_cmd_parser;

    localparam int unsigned C_TIMEOUT = 100;
    localparam int          C_TX_LEN  = 8;

    logic clk;
    logic rst;
    logic r_hold;
    int   m_cnt;
    int   n_starts;
    int   n_ferr;
    int   n_viol;
    int   n_vec;
    int   n_err;

    uart_cmd_parser_if bus ();

    uart_cmd_parser #(
        .TIMEOUT_CYCLES (C_TIMEOUT),
        .CNT_W          (24)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // TX FSM model: busy from the cycle after tx_start for C_TX_LEN cycles, plus forced hold.
    assign bus.tx_busy = r_hold || (m_cnt != 0);

    initial begin
        m_cnt    = 0;
        n_starts = 0;
        n_ferr   = 0;
        n_viol   = 0;
    end

    always @(posedge clk) begin
        if (bus.tx_start) begin
            n_starts <= n_starts + 1;
            if (bus.tx_busy) n_viol <= n_viol + 1;
        end
        if (bus.frame_err) n_ferr <= n_ferr + 1;
        if (bus.tx_start && !bus.tx_busy) m_cnt <= C_TX_LEN;
        else if (m_cnt != 0)              m_cnt <= m_cnt - 1;
    end

    task automatic send_byte(input logic [7:0] b, input logic perr);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        bus.rx_perr  = perr;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_perr  = 1'b0;
    endtask

    task automatic settle();
        repeat (25) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (bus.led_cmd !== 4'h0)   begin n_err++; $display("FAIL reset_led got %h want 0", bus.led_cmd); end
        n_vec++; if (bus.tx_start !== 1'b0)  begin n_err++; $display("FAIL reset_tx_start got %b want 0", bus.tx_start); end
        n_vec++; if (bus.tx_byte !== 8'h00)  begin n_err++; $display("FAIL reset_tx_byte got %h want 00", bus.tx_byte); end
        n_vec++; if (bus.frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err got %b want 0", bus.frame_err); end
        n_vec++; if (bus.drop_cnt !== 8'h00) begin n_err++; $display("FAIL reset_drop got %h want 00", bus.drop_cnt); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        int s0;
        s0 = n_starts;
        send_byte(8'h4C, 1'b0);
        send_byte(8'h35, 1'b0);
        send_byte(8'h0D, 1'b0);
        n_vec++; if (bus.led_cmd !== 4'h5)   begin n_err++; $display("FAIL write_led got %h want 5", bus.led_cmd); end
        n_vec++; if (bus.tx_start !== 1'b1)  begin n_err++; $display("FAIL write_tx_start got %b want 1", bus.tx_start); end
        n_vec++; if (bus.tx_byte !== 8'h4B)  begin n_err++; $display("FAIL write_reply got %h want 4b", bus.tx_byte); end
        n_vec++; if (bus.frame_err !== 1'b0) begin n_err++; $display("FAIL write_frame_err got %b want 0", bus.frame_err); end
        settle();
        n_vec++; if (n_starts - s0 !== 1)    begin n_err++; $display("FAIL write_starts got %0d want 1", n_starts - s0); end
    endtask

    task automatic test_read();
        send_byte(8'h4C, 1'b0);
        send_byte(8'h41, 1'b0);
        send_byte(8'h0D, 1'b0);
        settle();
        n_vec++; if (bus.led_cmd !== 4'hA)  begin n_err++; $display("FAIL read_setup_led got %h want a", bus.led_cmd); end
        send_byte(8'h52, 1'b0);
        send_byte(8'h0D, 1'b0);
        n_vec++; if (bus.tx_start !== 1'b1) begin n_err++; $display("FAIL read_tx_start got %b want 1", bus.tx_start); end
        n_vec++; if (bus.tx_byte !== 8'h41) begin n_err++; $display("FAIL read_reply got %h want 41", bus.tx_byte); end
        n_vec++; if (bus.led_cmd !== 4'hA)  begin n_err++; $display("FAIL read_led got %h want a", bus.led_cmd); end
        settle();
        send_byte(8'h4C, 1'b0);
        send_byte(8'h66, 1'b0);
        send_byte(8'h0D, 1'b0);
        n_vec++; if (bus.led_cmd !== 4'hF)  begin n_err++; $display("FAIL lower_hex_led got %h want f", bus.led_cmd); end
        n_vec++; if (bus.tx_byte !== 8'h4B) begin n_err++; $display("FAIL lower_hex_reply got %h want 4b", bus.tx_byte); end
        settle();
    endtask

    task automatic test_idle_ignore();
        int s0;
        s0 = n_starts;
        send_byte(8'h0D, 1'b0);
        send_byte(8'h0A, 1'b0);
        settle();
        n_vec++; if (n_starts - s0 !== 0)    begin n_err++; $display("FAIL idle_crlf_starts got %0d want 0", n_starts - s0); end
        send_byte(8'h72, 1'b0);
        n_vec++; if (bus.frame_err !== 1'b1) begin n_err++; $display("FAIL lower_r_frame_err got %b want 1", bus.frame_err); end
        n_vec++; if (bus.tx_byte !== 8'h45)  begin n_err++; $display("FAIL lower_r_reply got %h want 45", bus.tx_byte); end
        settle();
    endtask

    task automatic test_bad_hex();
        int s0;
        int f0;
        s0 = n_starts;
        f0 = n_ferr;
        send_byte(8'h4C, 1'b0);
        send_byte(8'h47, 1'b0);
        n_vec++; if (bus.frame_err !== 1'b1) begin n_err++; $display("FAIL badhex_frame_err got %b want 1", bus.frame_err); end
        n_vec++; if (bus.tx_byte !== 8'h45)  begin n_err++; $display("FAIL badhex_reply got %h want 45", bus.tx_byte); end
        send_byte(8'h0D, 1'b0);
        n_vec++; if (bus.drop_cnt !== 8'd1)  begin n_err++; $display("FAIL badhex_drop got %0d want 1", bus.drop_cnt); end
        settle();
        n_vec++; if (n_starts - s0 !== 1)    begin n_err++; $display("FAIL badhex_starts got %0d want 1", n_starts - s0); end
        n_vec++; if (n_ferr - f0 !== 1)      begin n_err++; $display("FAIL badhex_ferr_count got %0d want 1", n_ferr - f0); end
        n_vec++; if (bus.led_cmd !== 4'hF)   begin n_err++; $display("FAIL badhex_led got %h want f", bus.led_cmd); end
    endtask

    task automatic test_timeout();
        int n;
        send_byte(8'h4C, 1'b0);
        n = 0;
        while ((bus.tx_start !== 1'b1) && (n < 300)) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_vec++; if (n !== 100)              begin n_err++; $display("FAIL timeout_cycles got %0d want 100", n); end
        n_vec++; if (bus.tx_byte !== 8'h45)  begin n_err++; $display("FAIL timeout_reply got %h want 45", bus.tx_byte); end
        n_vec++; if (bus.frame_err !== 1'b1) begin n_err++; $display("FAIL timeout_frame_err got %b want 1", bus.frame_err); end
        n_vec++; if (bus.led_cmd !== 4'hF)   begin n_err++; $display("FAIL timeout_led got %h want f", bus.led_cmd); end
        settle();
    endtask

    task automatic test_perr_busy();
        int s0;
        s0 = n_starts;
        @(negedge clk);
        r_hold = 1'b1;
        send_byte(8'h4C, 1'b0);
        send_byte(8'h33, 1'b1);
        n_vec++; if (bus.frame_err !== 1'b1) begin n_err++; $display("FAIL perr_frame_err got %b want 1", bus.frame_err); end
        n_vec++; if (bus.tx_byte !== 8'h45)  begin n_err++; $display("FAIL perr_reply got %h want 45", bus.tx_byte); end
        repeat (500) @(negedge clk);
        n_vec++; if (n_starts - s0 !== 0)    begin n_err++; $display("FAIL busy_hold_starts got %0d want 0", n_starts - s0); end
        r_hold = 1'b0;
        #1;
        n_vec++; if (bus.tx_start !== 1'b1)  begin n_err++; $display("FAIL busy_release_tx_start got %b want 1", bus.tx_start); end
        settle();
        n_vec++; if (n_starts - s0 !== 1)    begin n_err++; $display("FAIL busy_starts got %0d want 1", n_starts - s0); end
        n_vec++; if (bus.led_cmd !== 4'hF)   begin n_err++; $display("FAIL perr_led got %h want f", bus.led_cmd); end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h4C, 1'b0);
        send_byte(8'h31, 1'b0);
        send_byte(8'h0D, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.led_cmd !== 4'h0)   begin n_err++; $display("FAIL midrst_led got %h want 0", bus.led_cmd); end
        n_vec++; if (bus.tx_byte !== 8'h00)  begin n_err++; $display("FAIL midrst_tx_byte got %h want 00", bus.tx_byte); end
        n_vec++; if (bus.tx_start !== 1'b0)  begin n_err++; $display("FAIL midrst_tx_start got %b want 0", bus.tx_start); end
        n_vec++; if (bus.frame_err !== 1'b0) begin n_err++; $display("FAIL midrst_frame_err got %b want 0", bus.frame_err); end
        n_vec++; if (bus.drop_cnt !== 8'h00) begin n_err++; $display("FAIL midrst_drop got %h want 00", bus.drop_cnt); end
        rst = 1'b1;
        settle();
        send_byte(8'h52, 1'b0);
        send_byte(8'h0D, 1'b0);
        n_vec++; if (bus.tx_start !== 1'b1)  begin n_err++; $display("FAIL midrst_read_start got %b want 1", bus.tx_start); end
        n_vec++; if (bus.tx_byte !== 8'h30)  begin n_err++; $display("FAIL midrst_read_reply got %h want 30", bus.tx_byte); end
        settle();
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        r_hold       = 1'b0;
        rst          = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        bus.rx_perr  = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_idle_ignore();
        test_bad_hex();
        test_timeout();
        test_perr_busy();
        test_reset_mid();
        n_vec++; if (n_viol !== 0) begin n_err++; $display("FAIL start_while_busy got %0d want 0", n_viol); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
